// File: rtl/seq_det_pkg.sv
// Shared FSM encoding and default pattern for the sequence-detector arbiter.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam int DEF_PLEN = 4;
  localparam logic [DEF_PLEN-1:0] DEF_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_match_core.sv
// Serial PLEN-bit pattern matcher; hit is combinational on the incoming bit and
// only fires once PLEN bits have been seen since the last clear.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PLEN = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic hit
);

  localparam int SW = $clog2(PLEN);
  localparam logic [SW-1:0] SEEN_MAX = SW'(PLEN - 1);

  logic [PLEN-2:0] hist;
  logic [SW-1:0]   seen;
  logic [PLEN-1:0] window;

  assign window = {hist, bit_in};

  // seen saturates at PLEN-1: the current bit completes the first full window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      seen <= '0;
    end else if (clr) begin
      hist <= '0;
      seen <= '0;
    end else if (en) begin
      hist <= window[PLEN-2:0];
      if (seen != SEEN_MAX) seen <= seen + SW'(1);
    end
  end

  assign hit = en && (seen == SEEN_MAX) && (window == PATTERN);

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter feeding one serial pattern matcher; each granted word is
// shifted MSB-first and its hit count and first-hit position are returned.
module seq_det_arbiter
  import seq_det_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int PLEN = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN,
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(DW + 1),
  localparam int FW = $clog2(DW)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IW-1:0]    rsp_id,
  output logic [CW-1:0]    rsp_count,
  output logic             rsp_hit,
  output logic [FW-1:0]    rsp_first
);

  state_t state, next_state;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand;
  logic          grant_any;
  logic          grant;
  logic [DW-1:0] word;
  logic [FW-1:0] bit_idx;
  logic          hit;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(rr_ptr) + i) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // reset_n gates the grant so no transfer is signalled while held in reset
  assign grant = (state == ST_IDLE) && grant_any && reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    unique case (state)
      ST_IDLE: begin
        if (grant) begin
          req_ready[grant_idx] = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_idx == FW'(DW - 1)) next_state = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      word      <= '0;
      bit_idx   <= '0;
      rsp_id    <= '0;
      rsp_count <= '0;
      rsp_first <= '0;
    end else if (grant) begin
      rr_ptr    <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
      word      <= req_data[int'(grant_idx)*DW +: DW];
      bit_idx   <= '0;
      rsp_id    <= grant_idx;
      rsp_count <= '0;
      rsp_first <= '0;
    end else if (state == ST_SHIFT) begin
      word    <= word << 1;
      bit_idx <= bit_idx + FW'(1);
      if (hit) begin
        rsp_count <= rsp_count + CW'(1);
        if (rsp_count == '0) rsp_first <= bit_idx;
      end
    end
  end

  seq_match_core #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_match (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (grant),
    .en      (state == ST_SHIFT),
    .bit_in  (word[DW-1]),
    .hit     (hit)
  );

  assign rsp_valid = (state == ST_RESP);
  assign rsp_hit   = (rsp_count != '0);

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: vector table plus arbitration, backpressure and
// mid-word reset sequences, with a scoreboard of expected responses.
module tb_seq_det_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int PLEN = 4;
  localparam logic [PLEN-1:0] PATTERN = 4'b1101;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [3:0]        rsp_count;
  logic              rsp_hit;
  logic [2:0]        rsp_first;

  always #5 clk = ~clk;

  seq_det_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_hit   (rsp_hit),
    .rsp_first (rsp_first)
  );

  typedef struct {
    int id;
    int count;
    int first;
  } exp_t;

  typedef struct {
    int          req;
    logic [7:0]  word;
    int          count;
    int          first;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference matcher: every window ending at bit p (0 = MSB) of the word
  function automatic void model(input logic [DW-1:0] w, output int cnt, output int first);
    logic [PLEN-1:0] win;
    cnt   = 0;
    first = 0;
    for (int p = PLEN - 1; p < DW; p++) begin
      for (int j = 0; j < PLEN; j++) win[PLEN-1-j] = w[DW-1-(p-PLEN+1+j)];
      if (win == PATTERN) begin
        if (cnt == 0) first = p;
        cnt++;
      end
    end
  endfunction

  task automatic push_model(input int id, input logic [DW-1:0] w);
    int c, f;
    model(w, c, f);
    sb_q.push_back('{id, c, f});
  endtask

  // Caller sits just after a negedge; grant is sampled #1 later
  task automatic wait_grant(input logic [NREQ-1:0] exp_ready, input string name);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready != '0) break;
      @(negedge clk);
    end
    check_eq({name, ".req_ready"}, int'(req_ready), int'(exp_ready));
  endtask

  task automatic apply_stimulus(input vec_t v, input string name);
    logic [NREQ-1:0] er;
    @(negedge clk);
    req_valid = '0;
    req_valid[v.req] = 1'b1;
    req_data[v.req*DW +: DW] = v.word;
    er = '0;
    er[v.req] = 1'b1;
    wait_grant(er, name);
    sb_q.push_back('{v.req, v.count, v.first});
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  // Called in the cycle after the grant edge; also checks grant-to-valid latency
  task automatic check_output(input string name);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 60);
    if (!rsp_valid) begin
      check_eq({name, ".rsp_valid"}, int'(rsp_valid), 1);
      return;
    end
    if (sb_q.size() == 0) begin
      check_eq({name, ".sb_size"}, sb_q.size(), 1);
      return;
    end
    e = sb_q.pop_front();
    check_eq({name, ".latency"}, n, DW + 1);
    check_eq({name, ".id"}, int'(rsp_id), e.id);
    check_eq({name, ".count"}, int'(rsp_count), e.count);
    check_eq({name, ".hit"}, int'(rsp_hit), (e.count != 0) ? 1 : 0);
    check_eq({name, ".first"}, int'(rsp_first), e.first);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int        hold_c, hold_f;
    logic [8:0] hold_fields;

    vecs[0] = '{0, 8'b1101_1010, 2, 3};
    vecs[1] = '{1, 8'b1101_1101, 2, 3};
    vecs[2] = '{2, 8'hFF,        0, 0};
    vecs[3] = '{3, 8'h0D,        1, 7};
    vecs[4] = '{1, 8'b0000_0110, 0, 0};
    vecs[5] = '{2, 8'b1000_0000, 0, 0};
    vecs[6] = '{0, 8'b0110_1101, 2, 4};
    vecs[7] = '{3, 8'b1101_0000, 1, 3};

    reset_n   = 1'b0;
    req_valid = 4'b0001;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset.req_ready", int'(req_ready), 0);
    check_eq("reset.rsp_valid", int'(rsp_valid), 0);
    check_eq("reset.rsp_fields", int'({rsp_id, rsp_count, rsp_hit, rsp_first}), 0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
      check_output($sformatf("vec%0d", i));
    end

    // All requesters valid: strict rotation 0,1,2,3,...
    do_reset();
    req_data[0*DW +: DW] = 8'b1101_1010;
    req_data[1*DW +: DW] = 8'h0D;
    req_data[2*DW +: DW] = 8'hFF;
    req_data[3*DW +: DW] = 8'b1101_1101;
    req_valid = 4'hF;
    for (int k = 0; k < 20; k++) begin
      logic [NREQ-1:0] er;
      er = '0;
      er[k % NREQ] = 1'b1;
      wait_grant(er, $sformatf("rr%0d", k));
      push_model(k % NREQ, req_data[(k % NREQ)*DW +: DW]);
      @(posedge clk);
      check_output($sformatf("rr%0d", k));
      if (k == 19) req_valid = '0;
      @(negedge clk);
    end

    // Backpressure: response held 30 cycles, competing request must wait
    rsp_ready = 1'b0;
    req_data[1*DW +: DW] = 8'b0110_1101;
    req_data[2*DW +: DW] = 8'b1101_0000;
    req_valid = 4'b0110;
    wait_grant(4'b0010, "bp_grant1");
    push_model(1, 8'b0110_1101);
    model(8'b0110_1101, hold_c, hold_f);
    hold_fields = {2'd1, 4'(hold_c), 3'(hold_f)};
    @(posedge clk);
    check_output("bp_rsp1");
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check_eq("bp_hold.rsp_valid", int'(rsp_valid), 1);
      check_eq("bp_hold.fields", int'({rsp_id, rsp_count, rsp_first}), int'(hold_fields));
      check_eq("bp_hold.req_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    wait_grant(4'b0100, "bp_grant2");
    push_model(2, 8'b1101_0000);
    @(posedge clk);
    #1 req_valid = '0;
    check_output("bp_rsp2");

    // Reset in the fourth SHIFT cycle aborts the word and restarts rotation at 0
    @(negedge clk);
    req_data[2*DW +: DW] = 8'b1101_1010;
    req_valid = 4'b0100;
    wait_grant(4'b0100, "abort_grant");
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort.rsp_valid", int'(rsp_valid), 0);
    check_eq("abort.rsp_count", int'(rsp_count), 0);
    @(negedge clk);
    req_data[0*DW +: DW] = 8'h0D;
    req_data[3*DW +: DW] = 8'b1101_1101;
    req_valid = 4'b1001;
    #1;
    check_eq("abort.ready_in_reset", int'(req_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_grant(4'b0001, "abort_regrant0");
    push_model(0, 8'h0D);
    @(posedge clk);
    #1 req_valid = 4'b1000;
    check_output("abort_rsp0");
    @(negedge clk);
    wait_grant(4'b1000, "abort_regrant3");
    push_model(3, 8'b1101_1101);
    @(posedge clk);
    #1 req_valid = '0;
    check_output("abort_rsp3");

    repeat (3) @(negedge clk);
    check_eq("idle.rsp_valid", int'(rsp_valid), 0);
    check_eq("idle.sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
